// File: rtl/ysyx_23060187_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_pkg
//  Description : Shared definitions for the instruction fetch unit. Holds the
//                FSM state encoding, the canonical NOP word delivered for
//                misaligned fetches, and a small alignment helper.
//  Contents    : C_STATE_W, C_ST_* state codes, C_NOP_INST, pc_is_aligned()
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060187_pkg;

    // FSM encoding (binary, explicit width)
    localparam int unsigned    C_STATE_W = 3;
    localparam logic [2:0]     C_ST_IDLE = 3'd0;  // waiting for a fetch address
    localparam logic [2:0]     C_ST_REQ  = 3'd1;  // memory request presented
    localparam logic [2:0]     C_ST_WAIT = 3'd2;  // request accepted, awaiting data
    localparam logic [2:0]     C_ST_HOLD = 3'd3;  // instruction offered to decode
    localparam logic [2:0]     C_ST_DROP = 3'd4;  // swallow the response of a killed fetch

    // addi x0, x0, 0 -- substituted for the instruction of a misaligned fetch
    localparam logic [31:0]    C_NOP_INST = 32'h0000_0013;

    // A fetch address is usable only when it is word aligned.
    function automatic logic pc_is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : ysyx_23060187_pkg
`default_nettype wire

// File: rtl/ysyx_23060187_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_ifu
//  Description : Single-outstanding instruction fetch unit. Accepts a fetch
//                address from the PC stage, issues one word read to
//                instruction memory, and offers the returned word to decode
//                through a valid/ready handshake. Redirects (flush) kill the
//                in-flight fetch; a response belonging to a killed fetch is
//                swallowed in DROP. Misaligned addresses bypass memory and
//                deliver a NOP flagged with inst_misalign.
//
//  Ports       : clk, rst_n            clock, asynchronous active-low reset
//                pc_valid/pc/pc_ready  fetch address handshake from PC stage
//                flush                 redirect, kills in-flight fetch
//                mem_req_*             read request to instruction memory
//                mem_rsp_*             read response (always accepted)
//                inst_valid/inst/inst_pc/inst_misalign/inst_ready
//                                      instruction handshake to decode
//                fetch_cnt             number of instructions delivered
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060187_ifu
    import ysyx_23060187_pkg::*;
#(
    parameter int XLEN = 32                     // address/data width, fixed at 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // PC stage
    input  logic              pc_valid,
    input  logic [XLEN-1:0]   pc,
    output logic              pc_ready,
    input  logic              flush,
    // instruction memory
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    // decode
    output logic              inst_valid,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_misalign,
    input  logic              inst_ready,
    // statistics
    output logic [XLEN-1:0]   fetch_cnt
);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_nxt;
    logic                 r_flush_pend;     // flush seen while request not yet accepted
    logic [XLEN-1:0]      r_inst;
    logic [XLEN-1:0]      r_inst_pc;        // also the latched request address
    logic                 r_misalign;
    logic [XLEN-1:0]      r_fetch_cnt;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_accept;       // new fetch address taken this cycle
    logic w_aligned;      // the offered address is word aligned
    logic w_req_fire;     // memory accepts our request this cycle
    logic w_kill_req;     // the accepted request belongs to a killed fetch
    logic w_deliver;      // decode consumes the instruction (and it counts)

    // pc_ready is gated with rst_n so that nothing is accepted while the
    // block is held in reset, even though the state already reads IDLE.
    assign pc_ready   = rst_n && (r_state == C_ST_IDLE) && !flush;
    assign w_accept   = pc_valid && pc_ready;
    assign w_aligned  = pc_is_aligned(pc);

    assign mem_req_valid = (r_state == C_ST_REQ);
    assign mem_req_addr  = {r_inst_pc[XLEN-1:2], 2'b00};
    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign w_kill_req    = flush || r_flush_pend;

    assign inst_valid    = (r_state == C_ST_HOLD);
    assign w_deliver     = inst_valid && inst_ready && !flush;

    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign inst_misalign = r_misalign;
    assign fetch_cnt     = r_fetch_cnt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                // flush forces pc_ready low, so no acceptance under flush
                if (w_accept) begin
                    w_state_nxt = w_aligned ? C_ST_REQ : C_ST_HOLD;
                end
            end
            C_ST_REQ: begin
                // The request is never withdrawn: a flush only redirects
                // where the accepted request ends up.
                if (w_req_fire) begin
                    w_state_nxt = w_kill_req ? C_ST_DROP : C_ST_WAIT;
                end
            end
            C_ST_WAIT: begin
                if (mem_rsp_valid) begin
                    // Data arriving alongside a flush is simply discarded;
                    // nothing remains outstanding so IDLE is safe.
                    w_state_nxt = flush ? C_ST_IDLE : C_ST_HOLD;
                end else if (flush) begin
                    w_state_nxt = C_ST_DROP;
                end
            end
            C_ST_HOLD: begin
                if (flush || inst_ready) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            C_ST_DROP: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky flush: remembers a redirect seen while the request waits for
    // mem_req_ready, since flush may be a single-cycle pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_pend <= 1'b0;
        end else if ((r_state == C_ST_REQ) && !w_req_fire) begin
            if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            r_flush_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Instruction datapath. Registers only change on acceptance or on a
    // useful response, so they are stable throughout HOLD.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_inst_pc  <= pc;
            r_misalign <= !w_aligned;
            if (!w_aligned) begin
                r_inst <= C_NOP_INST;
            end
        end else if ((r_state == C_ST_WAIT) && mem_rsp_valid && !flush) begin
            r_inst <= mem_rsp_data;
        end
    end

    // ------------------------------------------------------------------------
    // Delivered-instruction counter (wraps naturally)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (w_deliver) begin
            r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
    end

endmodule : ysyx_23060187_ifu
`default_nettype wire

// File: tb/tb_ysyx_23060187_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_23060187_ifu
//  Description : Directed self-checking bench for the instruction fetch unit.
//                Inputs change 1 ns after the rising edge; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060187_ifu;

    logic        clk;
    logic        rst_n;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misalign;
    logic        inst_ready;
    logic [31:0] fetch_cnt;

    int n_checks;
    int n_fail;

    ysyx_23060187_ifu #(.XLEN(32)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .pc_ready      (pc_ready),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_misalign (inst_misalign),
        .inst_ready    (inst_ready),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_valid      = 1'b0;
        pc            = 32'h0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        inst_ready    = 1'b0;
    endtask

    logic [31:0] held_inst;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        pc_valid = 1'b1;                // offered while in reset: must not be taken
        pc       = 32'h8000_0000;

        // ---------------- reset state ----------------
        next_cycle();
        settle();
        check("rst_pc_ready",   {31'd0, pc_ready},      32'd0);
        check("rst_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid},    32'd0);
        check("rst_inst",       inst,                   32'h0);
        check("rst_inst_pc",    inst_pc,                32'h0);
        check("rst_misalign",   {31'd0, inst_misalign}, 32'd0);
        check("rst_fetch_cnt",  fetch_cnt,              32'd0);

        // ---------------- zero-wait fetch ----------------
        next_cycle();
        rst_n         = 1'b1;            // cycle N: offer pc
        pc_valid      = 1'b1;
        pc            = 32'h8000_0000;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        settle();
        check("zw_pc_ready_N", {31'd0, pc_ready}, 32'd1);
        next_cycle();                    // N+1
        pc_valid = 1'b0;
        settle();
        check("zw_req_valid_N1", {31'd0, mem_req_valid}, 32'd1);
        check("zw_req_addr_N1",  mem_req_addr,           32'h8000_0000);
        next_cycle();                    // N+2: response
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0093;
        settle();
        check("zw_inst_valid_N2", {31'd0, inst_valid},    32'd0);
        check("zw_req_valid_N2",  {31'd0, mem_req_valid}, 32'd0);
        next_cycle();                    // N+3
        mem_rsp_valid = 1'b0;
        settle();
        check("zw_inst_valid_N3", {31'd0, inst_valid}, 32'd1);
        check("zw_inst",          inst,                32'h0010_0093);
        check("zw_inst_pc",       inst_pc,             32'h8000_0000);
        check("zw_misalign",      {31'd0, inst_misalign}, 32'd0);
        check("zw_pc_ready_hold", {31'd0, pc_ready},   32'd0);
        next_cycle();                    // N+4: consumed
        settle();
        check("zw_fetch_cnt",   fetch_cnt,            32'd1);
        check("zw_back_idle",   {31'd0, pc_ready},    32'd1);
        check("zw_inst_valid_N4", {31'd0, inst_valid}, 32'd0);

        // ---------------- flush in IDLE: no acceptance ----------------
        idle_inputs();
        pc_valid = 1'b1;
        pc       = 32'h8000_0100;
        flush    = 1'b1;
        settle();
        check("fi_pc_ready", {31'd0, pc_ready}, 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("fi_no_req", {31'd0, mem_req_valid}, 32'd0);
        check("fi_idle",   {31'd0, pc_ready},      32'd1);

        // ---------------- memory back-pressure ----------------
        pc_valid = 1'b1;
        pc       = 32'h8000_0010;
        next_cycle();                    // REQ, ready low 3 cycles
        pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            settle();
            check($sformatf("bp_req_valid_%0d", i), {31'd0, mem_req_valid}, 32'd1);
            check($sformatf("bp_req_addr_%0d", i),  mem_req_addr,           32'h8000_0010);
            next_cycle();
        end
        mem_req_ready = 1'b0;            // WAIT, no response yet
        settle();
        check("bp_wait_req_low", {31'd0, mem_req_valid}, 32'd0);
        check("bp_wait_no_inst", {31'd0, inst_valid},    32'd0);
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0020_0113;
        next_cycle();
        mem_rsp_valid = 1'b0;
        inst_ready    = 1'b1;
        settle();
        check("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("bp_inst",       inst,                32'h0020_0113);
        next_cycle();
        inst_ready = 1'b0;
        settle();
        check("bp_single_inst", {31'd0, inst_valid}, 32'd0);
        check("bp_fetch_cnt",   fetch_cnt,           32'd2);

        // ---------------- flush in WAIT ----------------
        pc_valid      = 1'b1;
        pc            = 32'h8000_0020;
        mem_req_ready = 1'b1;
        next_cycle();                    // REQ
        pc_valid = 1'b0;
        next_cycle();                    // WAIT
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        next_cycle();                    // DROP
        flush         = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        check("fw_no_inst_drop", {31'd0, inst_valid}, 32'd0);
        check("fw_busy_drop",    {31'd0, pc_ready},   32'd0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        settle();
        check("fw_no_inst_after", {31'd0, inst_valid}, 32'd0);
        check("fw_pc_ready",      {31'd0, pc_ready},   32'd1);
        check("fw_fetch_cnt",     fetch_cnt,           32'd2);
        check("fw_inst_kept",     inst,                32'h0020_0113);

        // ---------------- misaligned fetch + decode stall ----------------
        pc_valid = 1'b1;
        pc       = 32'h8000_0002;
        next_cycle();                    // HOLD directly
        pc_valid   = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("ma_req_valid_%0d", i),  {31'd0, mem_req_valid}, 32'd0);
            check($sformatf("ma_inst_valid_%0d", i), {31'd0, inst_valid},    32'd1);
            check($sformatf("ma_inst_%0d", i),       inst,                   32'h0000_0013);
            check($sformatf("ma_inst_pc_%0d", i),    inst_pc,                32'h8000_0002);
            check($sformatf("ma_misalign_%0d", i),   {31'd0, inst_misalign}, 32'd1);
            check($sformatf("ma_pc_ready_%0d", i),   {31'd0, pc_ready},      32'd0);
            next_cycle();
        end
        inst_ready = 1'b1;
        next_cycle();
        inst_ready = 1'b0;
        settle();
        check("ma_idle",      {31'd0, pc_ready},   32'd1);
        check("ma_fetch_cnt", fetch_cnt,           32'd3);

        // ---------------- flush in HOLD together with inst_ready ----------------
        pc_valid      = 1'b1;
        pc            = 32'h8000_0030;
        mem_req_ready = 1'b1;
        next_cycle();                    // REQ
        pc_valid = 1'b0;
        next_cycle();                    // WAIT
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0030_0193;
        next_cycle();                    // HOLD
        mem_rsp_valid = 1'b0;
        held_inst     = inst;
        check("fh_inst", held_inst, 32'h0030_0193);
        flush      = 1'b1;
        inst_ready = 1'b1;
        next_cycle();
        flush      = 1'b0;
        inst_ready = 1'b0;
        settle();
        check("fh_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("fh_fetch_cnt",  fetch_cnt,           32'd3);

        // ---------------- pulsed flush while request stalled (sticky) ----------------
        pc_valid = 1'b1;
        pc       = 32'h8000_0040;
        next_cycle();                    // REQ, ready low
        pc_valid = 1'b0;
        flush    = 1'b1;
        next_cycle();                    // still REQ, flush gone
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        settle();
        check("sf_req_held", {31'd0, mem_req_valid}, 32'd1);
        next_cycle();                    // must be DROP
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        settle();
        check("sf_drop_busy", {31'd0, pc_ready}, 32'd0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        settle();
        check("sf_no_inst",   {31'd0, inst_valid}, 32'd0);
        check("sf_idle",      {31'd0, pc_ready},   32'd1);
        check("sf_fetch_cnt", fetch_cnt,           32'd3);

        // ---------------- reset during WAIT, late response ----------------
        pc_valid      = 1'b1;
        pc            = 32'h8000_0050;
        mem_req_ready = 1'b1;
        next_cycle();                    // REQ
        pc_valid = 1'b0;
        next_cycle();                    // WAIT
        mem_req_ready = 1'b0;
        rst_n         = 1'b0;
        #2;
        check("rw_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        check("rw_pc_ready",   {31'd0, pc_ready},      32'd0);
        check("rw_fetch_cnt",  fetch_cnt,              32'd0);
        check("rw_inst_pc",    inst_pc,                32'h0);
        next_cycle();
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2222_2222;
        next_cycle();
        mem_rsp_valid = 1'b0;
        settle();
        check("rw_no_inst",   {31'd0, inst_valid}, 32'd0);
        check("rw_inst",      inst,                32'h0);
        check("rw_idle",      {31'd0, pc_ready},   32'd1);
        check("rw_cnt_after", fetch_cnt,           32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ysyx_23060187_ifu
`default_nettype wire
